square_voice_sequencer: RTL
===========================

# square_voice_sequencer

Time-multiplexes one `Square` oscillator core across `VOICES` independent square-wave voices and mixes them into one sample per audio tick. The block holds per-voice state: sample, counter, wave length and enable. On each `sample_tick` it loads each voice into the core through its `set` path, captures the advanced state and accumulates the voice outputs into `mix_out`. It sits between the audio-rate tick generator and the output mixer/DAC path; register-side configuration arrives over a valid/ready write port.

## Interface
- `VOICES`, default 4: number of voices, 1..8.
- `AMP`, default 1<<20: initial voice amplitude magnitude.
- `clk` in, 1: the single clock.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `sample_tick` in, 1: one-cycle pulse requesting one mixed sample.
- `cfg_valid` in, 1: configuration write request.
- `cfg_ready` out, 1: write accepted when `cfg_valid && cfg_ready`.
- `cfg_voice` in, $clog2(VOICES) (min 1): target voice.
- `cfg_wave_length` in, 16: new wave length.
- `cfg_enable` in, 1: voice enable.
- `mix_out` out, 32+$clog2(VOICES), signed: sum of enabled voice samples.
- `mix_valid` out, 1: one-cycle pulse when `mix_out` is updated.
- `overrun` out, 1: sticky; a tick arrived while busy.

## Operation
- Per-voice state after reset:
  - sample = -AMP
  - counter = 1
  - wave_length = 0
  - enable = 0
- Output reset values: `mix_out` = 0, `mix_valid` = 0, `cfg_ready` = 1, `overrun` = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE + `sample_tick` -> RUN, issue index 0, accumulator cleared.
  - RUN: drive core `set` = 1 with the issued voice's sample/counter/wave_length, then increment the index. After issuing voice VOICES-1 -> DRAIN.
  - DRAIN: capture the last voice -> DONE.
  - DONE: register the accumulator into `mix_out`, pulse `mix_valid` -> IDLE.
- Capture, one cycle after issue:
  - If the voice is enabled, write core `out`/`counter` back to its state and add `out` (sign-extended) to the accumulator.
  - Disabled voices are issued but their state is frozen and they contribute 0.
- Core arithmetic, unchanged from `Square`: if counter*2 >= wave_length, the output is -sample and counter becomes 1; otherwise the output is sample and counter is incremented. wave_length = 0 therefore inverts the voice on every tick.
- Core `set` = 0 outside RUN; core output is ignored outside the capture cycle.
- Config write, accepted only in IDLE:
  - loads wave_length and enable
  - resets that voice's counter to 1 and sample to -AMP
- `cfg_ready` = 1 only in IDLE.
- `sample_tick` while not IDLE: tick dropped, `overrun` set.
- `sample_tick` and `cfg_valid` in the same IDLE cycle: the config write is accepted first, and the tick starts RUN using the new state.
- Reset mid-operation: all state returns to reset values immediately; no partial `mix_valid`.

## Timing
- Tick high in cycle 0:
  - voice i issued in cycle 1+i
  - voice i captured in cycle 2+i
- `mix_valid` is high in cycle VOICES+2; `mix_out` holds its value until the next DONE.
- Busy window is cycles 1..VOICES+2; the minimum tick spacing is VOICES+3 cycles.
- Config write latency: state is updated at the accepting edge and visible to the next issue.

## Configuration
- `SQUARE_SEQ_OVERRUN_EN`
  - Defined: overrun detection as above. `overrun` is sticky until `rst_n`.
  - Undefined: detection logic is omitted and `overrun` is tied to 0. Busy ticks are still dropped.

## Structure
- Package `square_seq_pkg`:
  - `voice_state_t` struct: int sample, shortint counter, 16-bit wave_length, enable
  - `seq_state_t` enum: IDLE/RUN/DRAIN/DONE
  - `AMP_DEFAULT` constant
- One sub-module, the existing `Square` core, instantiated once. Voice state is an array of `voice_state_t` inside the sequencer.

## Test plan
- Voice 0 enabled with wl=4, ticks every 8 cycles -> `mix_out` = -1048576, +1048576, +1048576, -1048576, -1048576 (period 4 ticks); `mix_valid` in cycle 6 after each tick.
- All 4 voices enabled with wl=4 -> `mix_out` = -4194304, +4194304, +4194304, -4194304.
- Voice 0 wl=4 enabled, voice 1 wl=0 enabled:
  - voice 1 alternates +AMP, -AMP starting at +1048576
  - first two mixes are 0 then 0
  - third mix is +1048576 + 1048576 = 2097152
- Tick in cycle 3 of a busy window -> tick ignored, `overrun` = 1 (0 with the macro undefined), the next `mix_valid` still arrives at cycle 6; `cfg_valid` during busy -> `cfg_ready` = 0 until IDLE.
- Config write plus tick in the same cycle -> first mix uses the new wave length; disabling voice 0 mid-stream -> contribution 0 and state frozen; re-enabling via write restarts it at -1048576.
- Assert `rst_n` low during RUN -> `mix_valid` = 0, `mix_out` = 0, `cfg_ready` = 1, all voices back to reset state.

Source files
------------

// File: rtl/square_seq_pkg.sv
// Shared types and constants for the square-wave voice sequencer.
// Holds the per-voice state record, the sequencer FSM states and the default amplitude.
package square_seq_pkg;

    localparam int AMP_DEFAULT = 1 << 20;

    typedef struct packed {
        int          sample;
        shortint     counter;
        logic [15:0] wave_length;
        logic        enable;
    } voice_state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/square_voice_sequencer_square.sv
// Square: single square-wave oscillator step, registered on set_i.
// Ports: clk, rst_n; set_i loads sample_i/counter_i/wave_length_i and
// advances one step; out_o/counter_o hold the advanced state next cycle.
module Square
    import square_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_i,
    input  int          sample_i,
    input  shortint     counter_i,
    input  logic [15:0] wave_length_i,
    output int          out_o,
    output shortint     counter_o
);

    int      out_q;
    shortint cnt_q;
    logic    wrap;

    // counter*2 >= wave_length, evaluated in 17 bits so nothing overflows
    assign wrap = {counter_i, 1'b0} >= {1'b0, wave_length_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 0;
            cnt_q <= 16'sd1;
        end else if (set_i) begin
            if (wrap) begin
                out_q <= -sample_i;
                cnt_q <= 16'sd1;
            end else begin
                out_q <= sample_i;
                cnt_q <= counter_i + 16'sd1;
            end
        end
    end

    assign out_o     = out_q;
    assign counter_o = cnt_q;

endmodule

// File: rtl/square_voice_sequencer.sv
// square_voice_sequencer: time-multiplexes one Square core over VOICES voices
// and sums the enabled voices into mix_out once per sample_tick.
// Ports: clk, rst_n (async, active-low); sample_tick starts a mix;
// cfg_valid/cfg_ready/cfg_voice/cfg_wave_length/cfg_enable write a voice
// (IDLE only); mix_out/mix_valid carry the result; overrun flags busy ticks.
// Macro SQUARE_SEQ_OVERRUN_EN enables the sticky overrun flag (else tied 0).
module square_voice_sequencer
    import square_seq_pkg::*;
#(
    parameter int VOICES = 4,
    parameter int AMP    = AMP_DEFAULT
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   sample_tick,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [(VOICES > 1 ? $clog2(VOICES) : 1)-1:0] cfg_voice,
    input  logic [15:0]                            cfg_wave_length,
    input  logic                                   cfg_enable,
    output logic signed [32+$clog2(VOICES)-1:0]    mix_out,
    output logic                                   mix_valid,
    output logic                                   overrun
);

    localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int MW = 32 + $clog2(VOICES);

    seq_state_t           state_q;
    voice_state_t         voice_q [VOICES];
    logic [IW-1:0]        idx_q;
    logic [IW-1:0]        cap_idx_q;
    logic                 cap_vld_q;
    logic signed [MW-1:0] acc_q;
    logic signed [MW-1:0] acc_d;
    logic signed [MW-1:0] mix_q;
    logic                 mix_valid_q;
    logic                 cfg_ready_q;

    logic        core_set;
    int          core_sample;
    shortint     core_counter;
    logic [15:0] core_wl;
    int          core_out;
    shortint     core_cnt;
    logic        cap_en;
    logic        cfg_fire;

    Square u_core (
        .clk           (clk),
        .rst_n         (rst_n),
        .set_i         (core_set),
        .sample_i      (core_sample),
        .counter_i     (core_counter),
        .wave_length_i (core_wl),
        .out_o         (core_out),
        .counter_o     (core_cnt)
    );

    // Core result is valid the cycle after a voice was issued.
    always_comb begin
        core_set     = (state_q == RUN);
        core_sample  = voice_q[idx_q].sample;
        core_counter = voice_q[idx_q].counter;
        core_wl      = voice_q[idx_q].wave_length;
        cap_en       = cap_vld_q && voice_q[cap_idx_q].enable;
        acc_d        = acc_q;
        if (cap_en) begin
            acc_d = acc_q + MW'(core_out);
        end
    end

    assign cfg_fire = cfg_valid && cfg_ready_q && (32'(cfg_voice) < VOICES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cap_idx_q   <= '0;
            cap_vld_q   <= 1'b0;
            acc_q       <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            cfg_ready_q <= 1'b1;
            for (int i = 0; i < VOICES; i++) begin
                voice_q[i].sample      <= -AMP;
                voice_q[i].counter     <= 16'sd1;
                voice_q[i].wave_length <= '0;
                voice_q[i].enable      <= 1'b0;
            end
        end else begin
            mix_valid_q <= 1'b0;
            cap_vld_q   <= core_set;
            cap_idx_q   <= idx_q;

            if (cap_en) begin
                voice_q[cap_idx_q].sample  <= core_out;
                voice_q[cap_idx_q].counter <= core_cnt;
            end

            // Only possible in IDLE, so never collides with a capture.
            if (cfg_fire) begin
                voice_q[cfg_voice].sample      <= -AMP;
                voice_q[cfg_voice].counter     <= 16'sd1;
                voice_q[cfg_voice].wave_length <= cfg_wave_length;
                voice_q[cfg_voice].enable      <= cfg_enable;
            end

            unique case (state_q)
                IDLE: begin
                    if (sample_tick) begin
                        state_q     <= RUN;
                        idx_q       <= '0;
                        acc_q       <= '0;
                        cfg_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (idx_q == IW'(VOICES - 1)) begin
                        idx_q   <= '0;
                        state_q <= DRAIN;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DRAIN: begin
                    mix_q       <= acc_d;
                    mix_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    state_q     <= IDLE;
                    cfg_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SQUARE_SEQ_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (sample_tick && state_q != IDLE) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    assign mix_out   = mix_q;
    assign mix_valid = mix_valid_q;
    assign cfg_ready = cfg_ready_q;

endmodule
